// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter and its pad/strobe stage.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 48;
  localparam int WAIT_CNT_W  = 4;
  localparam int STREAK_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_arb_pad.sv
// SRAM pin stage: registered strobes/address/data-out, dq tri-state buffer and read capture.
module sram_arb_pad
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_n_i,
  input  logic              oe_n_i,
  input  logic              we_n_i,
  input  logic              dq_oe_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] dq_out_i,
  input  logic              cap_en_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  inout  wire  [DATA_W-1:0] sram_dq_io,
  output logic              sram_ce_o,
  output logic              sram_oen_o,
  output logic              sram_wen_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              ce_q, oen_q, wen_q, dq_oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q;
  logic [DATA_W-1:0] rdata_q;

  // Inputs are next-cycle values, so the registered pins line up with the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q     <= 1'b1;
      oen_q    <= 1'b1;
      wen_q    <= 1'b1;
      dq_oe_q  <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
    end else begin
      ce_q     <= ce_n_i;
      oen_q    <= oe_n_i;
      wen_q    <= we_n_i;
      dq_oe_q  <= dq_oe_i;
      addr_q   <= addr_i;
      dq_out_q <= dq_out_i;
      if (cap_en_i) rdata_q <= sram_dq_io;
    end
  end

  assign sram_dq_io  = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
  assign sram_addr_o = addr_q;
  assign sram_ce_o   = ce_q;
  assign sram_oen_o  = oen_q;
  assign sram_wen_o  = wen_q;
  assign rdata_o     = rdata_q;

endmodule

// File: rtl/sram_arb.sv
// Two-port SRAM arbiter (A = video, high priority; B = system) with access sequencer.
// Build option SRAM_ARB_STARVE_GUARD_EN: grant B after MAX_STREAK A grants made while B waits.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_STREAK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic              busy,
  output logic              grant_b,
  output logic [1:0]        dbg_state
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_arb: WAIT_CYCLES must be 1..15");
  end
  if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_streak
    $error("sram_arb: MAX_STREAK must be 1..15");
  end

  // Handshake: a requester raises req with we/addr/wdata and holds all of them stable
  // until its one-cycle ack; inputs are latched when the grant is made in IDLE.
  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  grant_b_q, grant_b_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  last_wait;
  logic                  guard_b;
  logic                  pick_b;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [STREAK_W-1:0] streak_q, streak_d;

  assign guard_b = (streak_q == STREAK_W'(MAX_STREAK));

  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (!b_req || pick_b) streak_d = '0;
      else if (a_req)       streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end
`else
  assign guard_b = 1'b0;
`endif

  assign pick_b    = b_req && (!a_req || guard_b);
  assign last_wait = (wait_q == WAIT_CNT_W'(WAIT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant_b_d = grant_b_q;
    wait_d    = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          state_d   = ST_SETUP;
          grant_b_d = pick_b;
          we_d      = pick_b ? b_we    : a_we;
          addr_d    = pick_b ? b_addr  : a_addr;
          wdata_d   = pick_b ? b_wdata : a_wdata;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wait_d  = '0;
      end
      ST_ACCESS: begin
        if (last_wait) state_d = ST_DONE;
        else           wait_d  = wait_q + WAIT_CNT_W'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      grant_b_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      grant_b_q <= grant_b_d;
      wait_q    <= wait_d;
    end
  end

  // Pin values are decoded from the next state so the pad registers match the state.
  logic strobe_win;
  assign strobe_win = (state_d == ST_SETUP) || (state_d == ST_ACCESS);

  sram_arb_pad #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pad (
    .clk         (clk),
    .rst         (rst),
    .ce_n_i      (!strobe_win),
    .oe_n_i      (!(strobe_win && !we_d)),
    .we_n_i      (!((state_d == ST_ACCESS) && we_d)),
    .dq_oe_i     (we_d && (state_d != ST_IDLE)),
    .addr_i      (addr_d),
    .dq_out_i    (wdata_d),
    .cap_en_i    ((state_q == ST_ACCESS) && last_wait && !we_q),
    .sram_addr_o (sram_addr),
    .sram_dq_io  (sram_dq),
    .sram_ce_o   (sram_ce),
    .sram_oen_o  (sram_oen),
    .sram_wen_o  (sram_wen),
    .rdata_o     (rdata)
  );

  assign a_ack     = (state_q == ST_DONE) && !grant_b_q && !rst;
  assign b_ack     = (state_q == ST_DONE) &&  grant_b_q && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign grant_b   = grant_b_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: directed timing scenarios plus randomized two-port traffic.
module tb_sram_arb;
  import sram_arb_pkg::*;

  localparam int AW  = 20;
  localparam int DW  = 48;
  localparam int WC  = 2;
  localparam int WC1 = 1;
  localparam int MS  = 4;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ack, b_ack, sram_ce, sram_oen, sram_wen, busy, grant_b;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_addr;
  logic [1:0]    dbg_state;
  wire  [DW-1:0] sram_dq;

  logic [DW-1:0] sram_mem [0:63] = '{default: '0};
  logic [DW-1:0] ref_mem  [0:63] = '{default: '0};
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];

  assign sram_dq = (!sram_ce && !sram_oen) ? sram_mem[sram_addr[5:0]] : {DW{1'bz}};
  always @(posedge clk) if (!sram_ce && !sram_wen) sram_mem[sram_addr[5:0]] <= sram_dq;

  sram_arb #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce(sram_ce), .sram_oen(sram_oen), .sram_wen(sram_wen),
    .busy(busy), .grant_b(grant_b), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (WAIT_CYCLES = 1), read-only ROM model ----------------
  logic          p1_a_req = 0;
  logic [AW-1:0] p1_a_addr = '0;
  logic          p1_a_ack, p1_b_ack, p1_ce, p1_oen, p1_wen, p1_busy, p1_grant_b;
  logic [DW-1:0] p1_rdata;
  logic [AW-1:0] p1_addr;
  logic [1:0]    p1_state;
  wire  [DW-1:0] p1_dq;

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
    return {8'hA5, a, ~a};
  endfunction

  assign p1_dq = (!p1_ce && !p1_oen) ? model_word(p1_addr) : {DW{1'bz}};

  sram_arb #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC1), .MAX_STREAK(MS)) dut1 (
    .clk(clk), .rst(rst),
    .a_req(p1_a_req), .a_we(1'b0), .a_addr(p1_a_addr), .a_wdata({DW{1'b0}}), .a_ack(p1_a_ack),
    .b_req(1'b0), .b_we(1'b0), .b_addr({AW{1'b0}}), .b_wdata({DW{1'b0}}), .b_ack(p1_b_ack),
    .rdata(p1_rdata), .sram_addr(p1_addr), .sram_dq(p1_dq),
    .sram_ce(p1_ce), .sram_oen(p1_oen), .sram_wen(p1_wen),
    .busy(p1_busy), .grant_b(p1_grant_b), .dbg_state(p1_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_wdata = 48'hFFFF_0000_FFFF; p1_a_req = 1'b1;
    repeat (3) tick();
    checks++; if ({sram_ce, sram_oen, sram_wen} !== 3'b111) begin errors++; $display("FAIL reset_strobes got=%b exp=111", {sram_ce, sram_oen, sram_wen}); end
    checks++; if ({a_ack, b_ack, busy, grant_b} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {a_ack, b_ack, busy, grant_b}); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (sram_dq === a_wdata) begin errors++; $display("FAIL reset_dq_released got=%h", sram_dq); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    checks++; if ({p1_a_ack, p1_busy, p1_rdata} !== '0) begin errors++; $display("FAIL reset_dut1 got ack=%b busy=%b rdata=%h", p1_a_ack, p1_busy, p1_rdata); end
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; p1_a_req = 0;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_write();
    int c0, k;
    logic [DW-1:0] d;
    d = 48'h1234_5678_9ABC;
    b_we = 1; b_addr = 20'h00010; b_wdata = d; b_req = 1; c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      tick(); k = cyc - c0;
      checks++; if (sram_wen !== !(k >= 2 && k <= 1 + WC)) begin errors++; $display("FAIL write_wen cyc=%0d got=%b", k, sram_wen); end
      checks++; if (sram_ce !== !(k >= 1 && k <= 1 + WC)) begin errors++; $display("FAIL write_ce cyc=%0d got=%b", k, sram_ce); end
      checks++;
      if ((k >= 1 && k <= 2 + WC) ? (sram_dq !== d) : (sram_dq === d)) begin
        errors++; $display("FAIL write_dq cyc=%0d got=%h drive_expected=%b", k, sram_dq, (k >= 1 && k <= 2 + WC));
      end
      checks++; if (b_ack !== (k == 2 + WC) || a_ack !== 1'b0) begin errors++; $display("FAIL write_ack cyc=%0d got a=%b b=%b", k, a_ack, b_ack); end
      if (b_ack) b_req = 0;
    end
    checks++; if (sram_mem[16] !== d) begin errors++; $display("FAIL write_mem got=%h exp=%h", sram_mem[16], d); end
    ref_mem[16] = d;
    b_req = 0; b_we = 0;
    repeat (2) tick();
  endtask

  task automatic test_read();
    int c0, k;
    logic [DW-1:0] junk;
    junk = {16'($urandom), $urandom} | 48'h1;
    b_we = 0; b_addr = 20'h00010; b_wdata = junk; b_req = 1; c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      tick(); k = cyc - c0;
      checks++; if (sram_oen !== !(k >= 1 && k <= 1 + WC) || sram_wen !== 1'b1) begin errors++; $display("FAIL read_oen cyc=%0d got oen=%b wen=%b", k, sram_oen, sram_wen); end
      checks++;
      if (!sram_oen ? (sram_dq !== ref_mem[16]) : (sram_dq === junk)) begin
        errors++; $display("FAIL read_dq cyc=%0d got=%h", k, sram_dq);
      end
      checks++; if (b_ack !== (k == 2 + WC)) begin errors++; $display("FAIL read_ack cyc=%0d got=%b", k, b_ack); end
      if (k >= 2 + WC) begin
        checks++; if (rdata !== 48'h1234_5678_9ABC) begin errors++; $display("FAIL read_rdata cyc=%0d got=%h exp=123456789abc", k, rdata); end
      end
      if (b_ack) b_req = 0;
    end
    b_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_priority();
    int c0, k;
    logic [DW-1:0] wd;
    wd = {16'($urandom), $urandom};
    a_we = 1; a_addr = 20'h3; a_wdata = wd;
    b_we = 0; b_addr = 20'h10;
    a_req = 1; b_req = 1; c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      tick(); k = cyc - c0;
      checks++; if (a_ack !== (k == 2 + WC)) begin errors++; $display("FAIL prio_a_ack cyc=%0d got=%b", k, a_ack); end
      checks++; if (b_ack !== (k == 2 * (3 + WC) - 1)) begin errors++; $display("FAIL prio_b_ack cyc=%0d got=%b", k, b_ack); end
      if (k == 1) begin
        checks++; if (grant_b !== 1'b0) begin errors++; $display("FAIL prio_grant_a got=%b exp=0", grant_b); end
      end
      if (k == 4 + WC) begin
        checks++; if (grant_b !== 1'b1) begin errors++; $display("FAIL prio_grant_b got=%b exp=1", grant_b); end
      end
      if (a_ack) a_req = 0;
      if (b_ack) begin
        b_req = 0;
        checks++; if (rdata !== ref_mem[16]) begin errors++; $display("FAIL prio_rdata got=%h exp=%h", rdata, ref_mem[16]); end
      end
    end
    ref_mem[3] = wd;
    a_req = 0; b_req = 0; a_we = 0;
    repeat (2) tick();
  endtask

  task automatic test_streak();
    bit exp_b[10];
    int streak, n, w;
    bit is_b, got;
    streak = 0;
    for (int i = 0; i < 10; i++) begin
      if (GUARD && streak == MS) begin exp_b[i] = 1; streak = 0; end
      else begin exp_b[i] = 0; streak++; end
    end
    a_we = 0; a_addr = 20'h3; b_we = 0; b_addr = 20'h10;
    a_req = 1; b_req = 1; n = 0; w = 0;
    while (n < 10 && w < 200) begin
      tick(); w++;
      if (a_ack || b_ack) begin
        is_b = b_ack;
        checks++; if (is_b !== exp_b[n]) begin errors++; $display("FAIL streak_grant idx=%0d got_b=%b exp_b=%b", n, is_b, exp_b[n]); end
        checks++; if (rdata !== ref_mem[is_b ? 16 : 3]) begin errors++; $display("FAIL streak_rdata idx=%0d got=%h", n, rdata); end
        n++;
        if (n == 10) a_req = 0;
      end
    end
    checks++; if (n != 10) begin errors++; $display("FAIL streak_timeout grants=%0d exp=10", n); end
    a_req = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (b_ack) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL streak_b_after_a got=no_ack exp=ack"); end
    b_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    logic [DW-1:0] d;
    int c0, k;
    d = 48'hDEAD_BEEF_0F0F;
    b_we = 1; b_addr = 20'h20; b_wdata = d; b_req = 1;
    repeat (2) tick();
    checks++; if (sram_wen !== 1'b0) begin errors++; $display("FAIL abort_in_access got wen=%b exp=0", sram_wen); end
    rst = 1; b_req = 0;
    tick();
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state got busy=%b state=%0d", busy, dbg_state); end
    checks++; if ({sram_ce, sram_oen, sram_wen} !== 3'b111) begin errors++; $display("FAIL abort_strobes got=%b exp=111", {sram_ce, sram_oen, sram_wen}); end
    checks++; if (sram_dq === d) begin errors++; $display("FAIL abort_dq_released got=%h", sram_dq); end
    checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin errors++; $display("FAIL abort_ack got a=%b b=%b exp=00", a_ack, b_ack); end
    rst = 0; b_we = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL abort_late_ack i=%0d got=%b", i, b_ack); end
    end
    b_addr = 20'h10; b_req = 1; c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      tick(); k = cyc - c0;
      checks++; if (b_ack !== (k == 2 + WC)) begin errors++; $display("FAIL abort_recover_ack cyc=%0d got=%b", k, b_ack); end
      if (b_ack) begin
        b_req = 0;
        checks++; if (rdata !== ref_mem[16]) begin errors++; $display("FAIL abort_recover_rdata got=%h exp=%h", rdata, ref_mem[16]); end
      end
    end
    b_req = 0;
    repeat (2) tick();
  endtask

  task automatic run_port(input bit pb, input int n);
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, ex;
    logic we;
    bit got;
    for (int t = 0; t < n; t++) begin
      we = 1'($urandom_range(0, 1));
      ad = pb ? AW'($urandom_range(40, 55)) : AW'($urandom_range(0, 15));
      wd = {16'($urandom), $urandom};
      if (pb) begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1; end
      else    begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1; end
      if (!we) begin
        if (pb) exp_b_q.push_back(ref_mem[ad[5:0]]);
        else    exp_a_q.push_back(ref_mem[ad[5:0]]);
      end
      got = 0;
      for (int w = 0; w < 60 && !got; w++) begin
        tick();
        if (pb ? b_ack : a_ack) got = 1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL rand_timeout port=%s txn=%0d", pb ? "B" : "A", t);
        if (!we) begin
          if (pb) void'(exp_b_q.pop_front()); else void'(exp_a_q.pop_front());
        end
      end else if (we) begin
        ref_mem[ad[5:0]] = wd;
      end else begin
        ex = pb ? exp_b_q.pop_front() : exp_a_q.pop_front();
        checks++; if (rdata !== ex) begin errors++; $display("FAIL rand_rdata port=%s addr=%h got=%h exp=%h", pb ? "B" : "A", ad, rdata, ex); end
      end
      if (pb) b_req = 0; else a_req = 0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_random();
    fork
      run_port(1'b0, 14);
      run_port(1'b1, 14);
    join
    a_req = 0; b_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] adrs[4];
    int c0, k, n;
    for (int i = 0; i < 4; i++) adrs[i] = AW'($urandom);
    p1_a_addr = adrs[0]; p1_a_req = 1; c0 = cyc; n = 0;
    for (int w = 0; w < 30 && n < 4; w++) begin
      tick(); k = cyc - c0;
      if (p1_a_ack) begin
        checks++; if (k != (2 + WC1) + (3 + WC1) * n) begin errors++; $display("FAIL b2b_ack_cycle idx=%0d got=%0d exp=%0d", n, k, (2 + WC1) + (3 + WC1) * n); end
        checks++; if (p1_rdata !== model_word(adrs[n])) begin errors++; $display("FAIL b2b_rdata idx=%0d got=%h exp=%h", n, p1_rdata, model_word(adrs[n])); end
        n++;
        if (n < 4) p1_a_addr = adrs[n]; else p1_a_req = 0;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_timeout acks=%0d exp=4", n); end
    p1_a_req = 0;
    repeat (2) tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_streak();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
